// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and execute-stage operand select for the 5-stage
// RISC-V core. The decoded instruction is captured on each rising clock edge.
// Flush replaces it with a bubble. Stall holds it. The ALU operands and the
// store data are then selected from the registered read data, or from values
// forwarded out of the MEM and WB stages.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   -> MEM/WB forwarding muxes are built
//                     undefined -> operands come straight from the registered
//                                  read data, fwd codes tie to 00 and the
//                                  mem_*/wb_* inputs are ignored
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   stall_i, flush_i              hold the stage / insert a bubble
//   id_*                          decoded instruction fields from decode
//   mem_rd_i/_reg_write_i/_alu_result_i   EX/MEM forwarding source
//   wb_rd_i/_reg_write_i/_result_i        MEM/WB forwarding source
//   ex_src_a_o, ex_src_b_o        ALU operands
//   ex_write_data_o               forwarded rs2 value for stores
//   ex_*                          registered fields carried to EX/MEM
//   ex_fwd_a_o, ex_fwd_b_o        forward-select codes (10 MEM, 01 WB, 00 RF)
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_rd1_i,
   input  logic [XLEN-1:0] id_rd2_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic [RA_W-1:0] id_rd_i,
   input  logic [2:0]      id_alu_control_i,
   input  logic            id_alu_src_i,
   input  logic            id_reg_write_i,
   input  logic            id_mem_write_i,
   input  logic            id_branch_i,
   input  logic [1:0]      id_result_src_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_reg_write_i,
   input  logic [XLEN-1:0] mem_alu_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_reg_write_i,
   input  logic [XLEN-1:0] wb_result_i,
   output logic [XLEN-1:0] ex_src_a_o,
   output logic [XLEN-1:0] ex_src_b_o,
   output logic [XLEN-1:0] ex_write_data_o,
   output logic [2:0]      ex_alu_control_o,
   output logic [RA_W-1:0] ex_rd_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic            ex_reg_write_o,
   output logic            ex_mem_write_o,
   output logic            ex_branch_o,
   output logic            ex_valid_o,
   output logic [1:0]      ex_result_src_o,
   output logic [1:0]      ex_fwd_a_o,
   output logic [1:0]      ex_fwd_b_o
);

   // All captured fields live in one packed record, so reset and flush can
   // clear the whole stage in one assignment.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic [2:0]      aluControl;
      logic            aluSrc;
      logic            regWrite;
      logic            memWrite;
      logic            branch;
      logic [1:0]      resultSrc;
   } stageFields_t;

   stageFields_t stage_q;
   stageFields_t stage_d;

   logic [XLEN-1:0] fwdRs1;
   logic [XLEN-1:0] fwdRs2;

   // Next-state selection. Flush beats stall, and stall beats a normal load.
   // The side-effecting control bits load only when decode marks the slot
   // valid. An invalid slot therefore enters as a harmless bubble even
   // without a flush.
   always_comb begin
      stage_d = stage_q;
      if (flush_i) begin
         stage_d = '0;
      end else if (!stall_i) begin
         stage_d.valid      = id_valid_i;
         stage_d.rd1        = id_rd1_i;
         stage_d.rd2        = id_rd2_i;
         stage_d.imm        = id_imm_i;
         stage_d.pc         = id_pc_i;
         stage_d.rs1        = id_rs1_i;
         stage_d.rs2        = id_rs2_i;
         stage_d.rd         = id_rd_i;
         stage_d.aluControl = id_alu_control_i;
         stage_d.aluSrc     = id_alu_src_i;
         stage_d.resultSrc  = id_result_src_i;
         stage_d.regWrite   = id_valid_i & id_reg_write_i;
         stage_d.memWrite   = id_valid_i & id_mem_write_i;
         stage_d.branch     = id_valid_i & id_branch_i;
      end
   end

   // Stage register. An asynchronous reset leaves an all-zero bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

`ifdef ID_EX_FORWARD_EN
   // Forward code for one source register. The youngest producer (MEM) wins
   // over WB. x0 never forwards, because writes to it are discarded.
   function automatic logic [1:0] fwdSelect(input logic [RA_W-1:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs)) begin
         sel = 2'b10;
      end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Forwarding works on the registered source addresses and the live
   // MEM/WB buses. It runs even for bubbles. The gated control bits keep a
   // bubble harmless downstream.
   always_comb begin
      ex_fwd_a_o = fwdSelect(stage_q.rs1);
      ex_fwd_b_o = fwdSelect(stage_q.rs2);
      case (ex_fwd_a_o)
         2'b10:   fwdRs1 = mem_alu_result_i;
         2'b01:   fwdRs1 = wb_result_i;
         default: fwdRs1 = stage_q.rd1;
      endcase
      case (ex_fwd_b_o)
         2'b10:   fwdRs2 = mem_alu_result_i;
         2'b01:   fwdRs2 = wb_result_i;
         default: fwdRs2 = stage_q.rd2;
      endcase
   end
`else
   // Without forwarding, hazards are resolved by stalls elsewhere. The
   // operands are the register-file values captured at decode.
   assign ex_fwd_a_o = 2'b00;
   assign ex_fwd_b_o = 2'b00;
   assign fwdRs1     = stage_q.rd1;
   assign fwdRs2     = stage_q.rd2;

   // This build ignores the forwarding sources and the registered source
   // addresses. They are folded into one sink net here.
   logic unusedFwdSources;
   assign unusedFwdSources = ^{mem_rd_i, mem_reg_write_i, mem_alu_result_i,
                               wb_rd_i, wb_reg_write_i, wb_result_i,
                               stage_q.rs1, stage_q.rs2};
`endif

   // Operand B takes the immediate for I-type and store addressing. Store
   // data always uses the (possibly forwarded) rs2 value.
   assign ex_src_a_o       = fwdRs1;
   assign ex_src_b_o       = stage_q.aluSrc ? stage_q.imm : fwdRs2;
   assign ex_write_data_o  = fwdRs2;

   assign ex_alu_control_o = stage_q.aluControl;
   assign ex_rd_o          = stage_q.rd;
   assign ex_pc_o          = stage_q.pc;
   assign ex_imm_o         = stage_q.imm;
   assign ex_reg_write_o   = stage_q.regWrite;
   assign ex_mem_write_o   = stage_q.memWrite;
   assign ex_branch_o      = stage_q.branch;
   assign ex_valid_o       = stage_q.valid;
   assign ex_result_src_o  = stage_q.resultSrc;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage. Hand-computed vectors cover reset
// (including a reset asserted mid-cycle), load, MEM/WB forwarding priority,
// the x0 guard, stall, flush, flush-over-stall and the immediate path.
// When ID_EX_FORWARD_EN is undefined, the expected operands fall back to the
// registered read data and the forward codes are expected to be 00.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic        id_valid_i;
   logic [31:0] id_rd1_i;
   logic [31:0] id_rd2_i;
   logic [31:0] id_imm_i;
   logic [31:0] id_pc_i;
   logic [4:0]  id_rs1_i;
   logic [4:0]  id_rs2_i;
   logic [4:0]  id_rd_i;
   logic [2:0]  id_alu_control_i;
   logic        id_alu_src_i;
   logic        id_reg_write_i;
   logic        id_mem_write_i;
   logic        id_branch_i;
   logic [1:0]  id_result_src_i;
   logic [4:0]  mem_rd_i;
   logic        mem_reg_write_i;
   logic [31:0] mem_alu_result_i;
   logic [4:0]  wb_rd_i;
   logic        wb_reg_write_i;
   logic [31:0] wb_result_i;
   logic [31:0] ex_src_a_o;
   logic [31:0] ex_src_b_o;
   logic [31:0] ex_write_data_o;
   logic [2:0]  ex_alu_control_o;
   logic [4:0]  ex_rd_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_imm_o;
   logic        ex_reg_write_o;
   logic        ex_mem_write_o;
   logic        ex_branch_o;
   logic        ex_valid_o;
   logic [1:0]  ex_result_src_o;
   logic [1:0]  ex_fwd_a_o;
   logic [1:0]  ex_fwd_b_o;

   int checkCount;
   int passCount;

   id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .id_valid_i       (id_valid_i),
      .id_rd1_i         (id_rd1_i),
      .id_rd2_i         (id_rd2_i),
      .id_imm_i         (id_imm_i),
      .id_pc_i          (id_pc_i),
      .id_rs1_i         (id_rs1_i),
      .id_rs2_i         (id_rs2_i),
      .id_rd_i          (id_rd_i),
      .id_alu_control_i (id_alu_control_i),
      .id_alu_src_i     (id_alu_src_i),
      .id_reg_write_i   (id_reg_write_i),
      .id_mem_write_i   (id_mem_write_i),
      .id_branch_i      (id_branch_i),
      .id_result_src_i  (id_result_src_i),
      .mem_rd_i         (mem_rd_i),
      .mem_reg_write_i  (mem_reg_write_i),
      .mem_alu_result_i (mem_alu_result_i),
      .wb_rd_i          (wb_rd_i),
      .wb_reg_write_i   (wb_reg_write_i),
      .wb_result_i      (wb_result_i),
      .ex_src_a_o       (ex_src_a_o),
      .ex_src_b_o       (ex_src_b_o),
      .ex_write_data_o  (ex_write_data_o),
      .ex_alu_control_o (ex_alu_control_o),
      .ex_rd_o          (ex_rd_o),
      .ex_pc_o          (ex_pc_o),
      .ex_imm_o         (ex_imm_o),
      .ex_reg_write_o   (ex_reg_write_o),
      .ex_mem_write_o   (ex_mem_write_o),
      .ex_branch_o      (ex_branch_o),
      .ex_valid_o       (ex_valid_o),
      .ex_result_src_o  (ex_result_src_o),
      .ex_fwd_a_o       (ex_fwd_a_o),
      .ex_fwd_b_o       (ex_fwd_b_o)
   );

   // 10 ns clock. All stimulus and sampling happens 1 ns after a rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point. Every check is counted here, and a mismatch
   // prints one FAIL line.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one decoded instruction onto the id_* inputs.
   task automatic applyStimulus(input logic valid, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] aluCtrl, input logic aluSrc,
                                input logic regWrite, input logic memWrite,
                                input logic branch, input logic [1:0] resultSrc);
      id_valid_i       = valid;
      id_rd1_i         = rd1;
      id_rd2_i         = rd2;
      id_imm_i         = imm;
      id_pc_i          = pc;
      id_rs1_i         = rs1;
      id_rs2_i         = rs2;
      id_rd_i          = rd;
      id_alu_control_i = aluCtrl;
      id_alu_src_i     = aluSrc;
      id_reg_write_i   = regWrite;
      id_mem_write_i   = memWrite;
      id_branch_i      = branch;
      id_result_src_i  = resultSrc;
   endtask

   // Drives the MEM and WB forwarding sources.
   task automatic applyForward(input logic [4:0] memRd, input logic memRw,
                               input logic [31:0] memRes, input logic [4:0] wbRd,
                               input logic wbRw, input logic [31:0] wbRes);
      mem_rd_i         = memRd;
      mem_reg_write_i  = memRw;
      mem_alu_result_i = memRes;
      wb_rd_i          = wbRd;
      wb_reg_write_i   = wbRw;
      wb_result_i      = wbRes;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst        = 1'b1;
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                    3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      applyForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

      // Reset state
      stepClock();
      checkOutput("reset valid", 32'(ex_valid_o), 32'h0);
      checkOutput("reset srcA", ex_src_a_o, 32'h0);
      checkOutput("reset srcB", ex_src_b_o, 32'h0);
      checkOutput("reset fwdA", 32'(ex_fwd_a_o), 32'h0);
      rst = 1'b0;

      // Plain load with no forwarding match
      applyForward(5'd9, 1'b1, 32'hDEAD, 5'd10, 1'b1, 32'hBEEF);
      applyStimulus(1'b1, 32'd5, 32'd7, 32'h11, 32'h100, 5'd1, 5'd2, 5'd4,
                    3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
      stepClock();
      checkOutput("load srcA", ex_src_a_o, 32'd5);
      checkOutput("load srcB", ex_src_b_o, 32'd7);
      checkOutput("load wdata", ex_write_data_o, 32'd7);
      checkOutput("load fwdA", 32'(ex_fwd_a_o), 32'h0);
      checkOutput("load valid", 32'(ex_valid_o), 32'h1);
      checkOutput("load regWrite", 32'(ex_reg_write_o), 32'h1);
      checkOutput("load rd", 32'(ex_rd_o), 32'd4);
      checkOutput("load pc", ex_pc_o, 32'h100);
      checkOutput("load imm", ex_imm_o, 32'h11);
      checkOutput("load resultSrc", 32'(ex_result_src_o), 32'h1);

      // Reset asserted mid-cycle clears the outputs without a clock edge
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst valid", 32'(ex_valid_o), 32'h0);
      checkOutput("async rst srcA", ex_src_a_o, 32'h0);
      checkOutput("async rst pc", ex_pc_o, 32'h0);
      checkOutput("async rst regWrite", 32'(ex_reg_write_o), 32'h0);
      #1;
      rst = 1'b0;

      // MEM beats WB when both match rs1. Then WB takes over.
      applyForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'hAA, 32'hBB, 32'h0, 32'h104, 5'd3, 5'd6, 5'd7,
                    3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      stepClock();
      applyForward(5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20);
      #1;
      checkOutput("mem fwd srcA", ex_src_a_o, FWD_ON ? 32'h10 : 32'hAA);
      checkOutput("mem fwd code", 32'(ex_fwd_a_o), FWD_ON ? 32'h2 : 32'h0);
      checkOutput("mem fwd aluCtrl", 32'(ex_alu_control_o), 32'h1);
      mem_reg_write_i = 1'b0;
      #1;
      checkOutput("wb fwd srcA", ex_src_a_o, FWD_ON ? 32'h20 : 32'hAA);
      checkOutput("wb fwd code", 32'(ex_fwd_a_o), FWD_ON ? 32'h1 : 32'h0);

      // x0 is never forwarded, even with matching writers
      applyForward(5'd0, 1'b1, 32'h55, 5'd0, 1'b1, 32'h66);
      applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h108, 5'd0, 5'd0, 5'd1,
                    3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      stepClock();
      checkOutput("x0 fwdB", 32'(ex_fwd_b_o), 32'h0);
      checkOutput("x0 wdata", ex_write_data_o, 32'h0);
      checkOutput("x0 srcB", ex_src_b_o, 32'h0);

      // Stall for three cycles while decode keeps changing
      applyForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h111, 32'h222, 32'h33, 32'h200, 5'd6, 5'd7, 5'd8,
                    3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
      stepClock();
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h900 + 32'(i), 32'h800 + 32'(i), 32'h700,
                       32'h300 + 32'(i), 5'd9, 5'd10, 5'd11, 3'b101, 1'b1,
                       1'b1, 1'b0, 1'b0, 2'b01);
         stepClock();
         checkOutput("stall srcA", ex_src_a_o, 32'h111);
         checkOutput("stall srcB", ex_src_b_o, 32'h222);
         checkOutput("stall pc", ex_pc_o, 32'h200);
         checkOutput("stall rd", 32'(ex_rd_o), 32'd8);
         checkOutput("stall aluCtrl", 32'(ex_alu_control_o), 32'h1);
         checkOutput("stall memWrite", 32'(ex_mem_write_o), 32'h1);
         checkOutput("stall branch", 32'(ex_branch_o), 32'h1);
      end

      // Flush wins over a simultaneous stall
      flush_i = 1'b1;
      stepClock();
      checkOutput("flush valid", 32'(ex_valid_o), 32'h0);
      checkOutput("flush regWrite", 32'(ex_reg_write_o), 32'h0);
      checkOutput("flush memWrite", 32'(ex_mem_write_o), 32'h0);
      checkOutput("flush branch", 32'(ex_branch_o), 32'h0);
      checkOutput("flush rd", 32'(ex_rd_o), 32'h0);
      checkOutput("flush aluCtrl", 32'(ex_alu_control_o), 32'h0);
      flush_i = 1'b0;
      stall_i = 1'b0;

      // Immediate selects operand B. Store data still takes rs2 from WB.
      applyForward(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'd9);
      applyStimulus(1'b1, 32'h1, 32'h77, 32'hFFFFFFFC, 32'h20C, 5'd0, 5'd5,
                    5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      stepClock();
      checkOutput("imm srcB", ex_src_b_o, 32'hFFFFFFFC);
      checkOutput("imm wdata", ex_write_data_o, FWD_ON ? 32'd9 : 32'h77);
      checkOutput("imm fwdB", 32'(ex_fwd_b_o), FWD_ON ? 32'h1 : 32'h0);
      checkOutput("imm srcA", ex_src_a_o, 32'h1);

      // An invalid decode slot loads with its control bits gated off
      applyForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h4, 32'h4, 32'h0, 32'h210, 5'd1, 5'd1, 5'd3,
                    3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
      stepClock();
      checkOutput("invalid valid", 32'(ex_valid_o), 32'h0);
      checkOutput("invalid regWrite", 32'(ex_reg_write_o), 32'h0);
      checkOutput("invalid memWrite", 32'(ex_mem_write_o), 32'h0);
      checkOutput("invalid branch", 32'(ex_branch_o), 32'h0);
      checkOutput("invalid pc", ex_pc_o, 32'h210);

      // Flush alone clears a valid instruction
      applyStimulus(1'b1, 32'h4, 32'h4, 32'h0, 32'h214, 5'd1, 5'd1, 5'd3,
                    3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      flush_i = 1'b1;
      stepClock();
      flush_i = 1'b0;
      checkOutput("flush only valid", 32'(ex_valid_o), 32'h0);
      checkOutput("flush only pc", ex_pc_o, 32'h0);
      checkOutput("flush only srcA", ex_src_a_o, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
